tree_operand_scheduler: RTL and testbench
=========================================

// Module: tree_operand_scheduler
// PURPOSE
//  Upstream feeder/controller for the CLA_16 adder stage of the multi-operand tree adder.
//  - Buffers a burst of up to NUM_OPS operands.
//  - Reduces the burst pairwise, level by level as a binary tree, time-sharing one
//    external registered CLA: drives A/B/C0, captures sum, writes it back.
//  - Presents the final sum with a valid/ready handshake.
// PARAMETERS
//  W        17  operand width (matches CLA stage input width)
//  NUM_OPS   8  max operands per burst; power of two, >=2
//  ACC_W    W+$clog2(NUM_OPS)  internal/result width; overflow impossible
//  ADD_LAT   1  clock cycles from operands driven to add_sum valid (0..7)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        operand present
//  in_ready      out  1        scheduler accepts operand (high only in LOAD)
//  in_data       in   W        unsigned operand
//  in_last       in   1        final operand of burst (qualified by in_valid)
//  add_a         out  ACC_W    adder operand A
//  add_b         out  ACC_W    adder operand B
//  add_c0        out  1        adder carry-in, tied 0
//  add_sum       in   ACC_W+1  adder result; MSB ignored
//  result_valid  out  1        final sum available
//  result_ready  in   1        consumer takes result
//  result        out  ACC_W    final sum
//  busy          out  1        high in ISSUE/WAIT
// BEHAVIOUR
//  Reset (rst=1 at edge): state=LOAD, wr_ptr=0, level=0, pair=0.
//   Outputs: in_ready=1, add_a=add_b=0, add_c0=0, result_valid=0, result=0, busy=0.
//   Buffer contents undefined.
//  Reset mid-operation: aborts at once. Partial burst and any in-flight adder
//   result are discarded.
//  FSM states: LOAD -> ISSUE -> WAIT -> ... -> DONE -> LOAD.
//  LOAD:
//   - Accept on in_valid&in_ready; buf[wr_ptr] <= zero-extended in_data; wr_ptr++.
//   - Exit to ISSUE when the NUM_OPS-th operand is accepted, or on accepted in_last.
//   - On exit, slots wr_ptr..NUM_OPS-1 are zero-filled. The tree always runs full size.
//   - in_last on the NUM_OPS-th operand: same as full; no extra effect.
//  ISSUE (one cycle per addition):
//   - add_a=buf[2*pair], add_b=buf[2*pair+1], busy=1.
//   - Level L processes NUM_OPS>>(L+1) pairs.
//  WAIT:
//   - Holds add_a/add_b stable for ADD_LAT cycles.
//   - At the end of the last WAIT cycle (end of ISSUE if ADD_LAT=0):
//     buf[pair] <= add_sum[ACC_W-1:0].
//   - Same-level write-back never overwrites an unread operand (pair <= 2*pair).
//  Sequencing:
//   - After capture, pair++. When pair wraps at the level end: pair=0, level++.
//   - After the last level (log2 NUM_OPS levels): result <= buf[0], go to DONE.
//   - Otherwise return to ISSUE.
//  Timing:
//   - Each addition takes ADD_LAT+1 cycles.
//   - Reduction takes (NUM_OPS-1)*(ADD_LAT+1) cycles from the edge leaving LOAD.
//   - result_valid rises on the next edge.
//  DONE:
//   - result_valid=1, result held stable, in_ready=0.
//   - On result_valid&result_ready: result_valid<=0, wr_ptr<=0, state LOAD.
//   - Next burst accepted from the following cycle (no same-cycle bypass).
//  in_ready=0 outside LOAD; in_valid there is ignored.
//  add_a/add_b are 0 outside ISSUE/WAIT.
// TESTING
//  1. rst 2 cycles -> in_ready=1, result_valid=0, busy=0, add_a=add_b=0.
//  2. Operands 1..8 back-to-back, ADD_LAT=1 -> result=36 (0x24);
//     result_valid 14 cycles after the 8th accept edge +1.
//  3. 0x0DE3A then 0x0F0AE with in_last -> zero-padded; result=0x1CEE8.
//  4. 8 x 0x1FFFF -> result=0xFFFF8 (ACC_W=20); no overflow; add_c0 always 0.
//  5. Hold result_ready=0 10 cycles in DONE -> result stable, in_ready=0;
//     then one ready pulse -> result_valid drops and in_ready=1 next cycle.
//  6. rst asserted during level 1 of a burst -> next cycle in LOAD, busy=0;
//     new burst 5,7 +in_last -> result=12.

Source files
------------

// File: rtl/tree_operand_scheduler.sv
// Operand buffer and binary-tree reduction sequencer for one shared external CLA stage.
// Accepts a burst of operands, reduces them pairwise in levels, and hands back the total.
module tree_operand_scheduler #(
   parameter int W       = 17,
   parameter int NUM_OPS = 8,
   parameter int ACC_W   = W + $clog2(NUM_OPS),
   parameter int ADD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic [ACC_W-1:0] add_a,
   output logic [ACC_W-1:0] add_b,
   output logic             add_c0,
   input  logic [ACC_W:0]   add_sum,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [ACC_W-1:0] result,
   output logic             busy
);

   localparam int LOG = $clog2(NUM_OPS);
   localparam logic [2:0] LAT_LAST = 3'((ADD_LAT > 0) ? (ADD_LAT - 1) : 0);

   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      FINISH = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [LOG-1:0]   wr_ptr;
   logic [LOG-1:0]   level;
   logic [LOG-1:0]   pair;
   logic [2:0]       lat_cnt;
   logic [ACC_W-1:0] ops_buf [NUM_OPS];

   logic             accept;
   logic             load_done;
   logic             capture;
   logic             pair_last;
   logic             level_last;
   logic [LOG-1:0]   idx_a;
   logic [LOG-1:0]   idx_b;
   logic             unused_sum_msb;

   assign accept     = (state == LOAD) && in_valid;
   assign load_done  = accept && (in_last || (wr_ptr == LOG'(NUM_OPS - 1)));
   assign capture    = ((state == ISSUE) && (ADD_LAT == 0)) ||
                       ((state == WAIT) && (lat_cnt == LAT_LAST));
   assign pair_last  = (pair == LOG'((NUM_OPS >> (int'(level) + 1)) - 1));
   assign level_last = (level == LOG'(LOG - 1));
   assign idx_a      = LOG'({pair, 1'b0});
   assign idx_b      = idx_a | LOG'(1);
   // The adder's carry-out cannot be set because ACC_W already covers the full tree growth.
   assign unused_sum_msb = add_sum[ACC_W];

   assign in_ready = (state == LOAD);
   assign busy     = (state == ISSUE) || (state == WAIT);
   assign add_c0   = 1'b0;
   assign add_a    = busy ? ops_buf[idx_a] : {ACC_W{1'b0}};
   assign add_b    = busy ? ops_buf[idx_b] : {ACC_W{1'b0}};

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (load_done) state_next = ISSUE;
            else           state_next = LOAD;
         end
         ISSUE, WAIT: begin
            if (capture) begin
               if (pair_last && level_last) state_next = FINISH;
               else                         state_next = ISSUE;
            end else begin
               state_next = WAIT;
            end
         end
         FINISH:  state_next = DONE;
         DONE: begin
            if (result_ready) state_next = LOAD;
            else              state_next = DONE;
         end
         default: state_next = LOAD;
      endcase
   end

   // State register, tree counters and result hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         wr_ptr       <= {LOG{1'b0}};
         level        <= {LOG{1'b0}};
         pair         <= {LOG{1'b0}};
         lat_cnt      <= 3'd0;
         result       <= {ACC_W{1'b0}};
         result_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (accept)                              wr_ptr <= wr_ptr + LOG'(1);
         else if ((state == DONE) && result_ready) wr_ptr <= {LOG{1'b0}};
         if (load_done) begin
            level <= {LOG{1'b0}};
            pair  <= {LOG{1'b0}};
         end else if (capture) begin
            if (pair_last) begin
               pair  <= {LOG{1'b0}};
               level <= level + LOG'(1);
            end else begin
               pair  <= pair + LOG'(1);
            end
         end
         if (state == WAIT) lat_cnt <= lat_cnt + 3'd1;
         else               lat_cnt <= 3'd0;
         if (state == FINISH) begin
            result       <= ops_buf[0];
            result_valid <= 1'b1;
         end else if ((state == DONE) && result_ready) begin
            result_valid <= 1'b0;
         end
      end
   end

   // Operand storage: loading with zero padding of unused slots, then in-place write-back
   // (slot pair is always at or below 2*pair, so no unread operand is overwritten).
   always_ff @(posedge clk) begin
      if (accept) begin
         ops_buf[wr_ptr] <= ACC_W'(in_data);
         if (load_done) begin
            for (int i = 0; i < NUM_OPS; i++) begin
               if (LOG'(i) > wr_ptr) ops_buf[i] <= {ACC_W{1'b0}};
            end
         end
      end else if (capture) begin
         ops_buf[pair] <= add_sum[ACC_W-1:0];
      end
   end

endmodule

// File: tb/tb_tree_operand_scheduler.sv
// Scoreboard bench for tree_operand_scheduler with a registered one-cycle CLA model.
module tb_tree_operand_scheduler;

   localparam int W       = 17;
   localparam int NUM_OPS = 8;
   localparam int ACC_W   = 20;
   localparam int ADD_LAT = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic [ACC_W-1:0] add_a;
   logic [ACC_W-1:0] add_b;
   logic             add_c0;
   logic [ACC_W:0]   add_sum;
   logic             result_valid;
   logic             result_ready;
   logic [ACC_W-1:0] result;
   logic             busy;

   int               checks = 0;
   int               errors = 0;
   logic [ACC_W-1:0] exp_q [$];
   logic [W-1:0]     stim [NUM_OPS];
   int               stim_n;
   bit               c0_high;

   tree_operand_scheduler #(
      .W(W), .NUM_OPS(NUM_OPS), .ADD_LAT(ADD_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_sum(add_sum),
      .result_valid(result_valid), .result_ready(result_ready), .result(result),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // External registered CLA stage.
   always @(posedge clk)
      add_sum <= {1'b0, add_a} + {1'b0, add_b} + {{ACC_W{1'b0}}, add_c0};

   always @(negedge clk)
      if (add_c0 !== 1'b0) c0_high = 1'b1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_burst(input bit use_last);
      logic [ACC_W-1:0] s;
      int n;
      s = '0;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_wait: got %b want 1", in_ready);
      end
      for (int i = 0; i < stim_n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = stim[i];
         in_last  = use_last && (i == stim_n - 1);
         s        = s + ACC_W'(stim[i]);
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      exp_q.push_back(s);
   endtask

   task automatic wait_result(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (result_valid !== 1'b1 && n < 200);
   endtask

   task automatic take_result();
      logic [ACC_W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (result_valid !== 1'b1) begin
         errors++;
         $display("FAIL result_valid_high: got %b want 1", result_valid);
      end
      checks++;
      if (result !== e) begin
         errors++;
         $display("FAIL result_value: got %h want %h", result, e);
      end
      @(negedge clk);
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0) begin
         errors++;
         $display("FAIL result_valid_drop: got %b want 0", result_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_after_take: got %b want 1", in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      result_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_result_valid: got %b want 0", result_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++;
      if (add_a !== 20'h0 || add_b !== 20'h0) begin
         errors++; $display("FAIL rst_add_ops: got %h/%h want 0/0", add_a, add_b);
      end
      checks++;
      if (add_c0 !== 1'b0) begin errors++; $display("FAIL rst_add_c0: got %b want 0", add_c0); end
      checks++;
      if (result !== 20'h0) begin errors++; $display("FAIL rst_result: got %h want 0", result); end
      rst = 1'b0;
   endtask

   task automatic test_sequence();
      int n;
      for (int i = 0; i < NUM_OPS; i++) stim[i] = W'(i + 1);
      stim_n = NUM_OPS;
      send_burst(1'b0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL issue_flags: got busy=%b in_ready=%b want 1/0", busy, in_ready);
      end
      checks++;
      if (add_a !== 20'd1 || add_b !== 20'd2) begin
         errors++; $display("FAIL first_issue_ops: got %0d/%0d want 1/2", add_a, add_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (add_a !== 20'd1 || add_b !== 20'd2 || busy !== 1'b1) begin
         errors++; $display("FAIL wait_hold_ops: got %0d/%0d busy=%b want 1/2 busy=1", add_a, add_b, busy);
      end
      wait_result(n);
      checks++;
      if (n + 1 !== 15) begin errors++; $display("FAIL latency_seq: got %0d want 15", n + 1); end
      checks++;
      if (result !== 20'h00024) begin errors++; $display("FAIL sum_1_to_8: got %h want 00024", result); end
      take_result();
   endtask

   task automatic test_zero_pad();
      int n;
      stim[0] = 17'h0DE3A;
      stim[1] = 17'h0F0AE;
      stim_n  = 2;
      send_burst(1'b1);
      wait_result(n);
      checks++;
      if (n !== 15) begin errors++; $display("FAIL latency_pad: got %0d want 15", n); end
      checks++;
      if (result !== 20'h1CEE8) begin errors++; $display("FAIL pad_sum: got %h want 1CEE8", result); end
      take_result();
   endtask

   task automatic test_max();
      int n;
      c0_high = 1'b0;
      for (int i = 0; i < NUM_OPS; i++) stim[i] = 17'h1FFFF;
      stim_n = NUM_OPS;
      send_burst(1'b0);
      wait_result(n);
      checks++;
      if (result !== 20'hFFFF8) begin errors++; $display("FAIL max_sum: got %h want FFFF8", result); end
      take_result();
      checks++;
      if (c0_high !== 1'b0) begin errors++; $display("FAIL add_c0_zero: got 1 want 0"); end
   endtask

   task automatic test_backpressure();
      int n;
      stim[0] = 17'd100;
      stim[1] = 17'd200;
      stim[2] = 17'd300;
      stim_n  = 3;
      send_burst(1'b1);
      wait_result(n);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (result_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_q[0]) begin
            errors++;
            $display("FAIL hold_cycle_%0d: got valid=%b in_ready=%b result=%h want 1/0/%h",
                     k, result_valid, in_ready, result, exp_q[0]);
         end
      end
      take_result();
   endtask

   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < NUM_OPS; i++) stim[i] = W'(10 * (i + 1));
      stim_n = NUM_OPS;
      send_burst(1'b0);
      void'(exp_q.pop_back());
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_state: got in_ready=%b busy=%b valid=%b want 1/0/0",
                  in_ready, busy, result_valid);
      end
      checks++;
      if (add_a !== 20'h0 || add_b !== 20'h0) begin
         errors++; $display("FAIL mid_reset_ops: got %h/%h want 0/0", add_a, add_b);
      end
      @(negedge clk);
      rst = 1'b0;
      stim[0] = 17'd5;
      stim[1] = 17'd7;
      stim_n  = 2;
      send_burst(1'b1);
      wait_result(n);
      checks++;
      if (n !== 15) begin errors++; $display("FAIL latency_after_rst: got %0d want 15", n); end
      checks++;
      if (result !== 20'd12) begin errors++; $display("FAIL sum_after_rst: got %0d want 12", result); end
      take_result();
   endtask

   task automatic test_back_to_back();
      int n;
      for (int k = 0; k < 5; k++) begin
         stim_n = (k == 0) ? 1 : (k == 4) ? NUM_OPS : int'($urandom_range(2, NUM_OPS - 1));
         for (int i = 0; i < stim_n; i++) stim[i] = W'($urandom);
         send_burst(1'b1);
         wait_result(n);
         checks++;
         if (n !== 15) begin errors++; $display("FAIL latency_b2b_%0d: got %0d want 15", k, n); end
         take_result();
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_zero_pad();
      test_max();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
